// File: rtl/pwm_multi_generator.sv
// ---------------------------------------------------------------------------
// pwm_multi_generator
//
// Multi-channel PWM generator driven from one shared period counter. Each
// channel owns a RISE/FALL pair. New pairs are written into shadow registers
// and copied to the active registers only on the last tick of a period,
// so a duty or phase change always starts cleanly at TIME_CNT = 0.
//
// Ports
//   CLK       system clock
//   RST_N     asynchronous active-low reset
//   TIME_CNT  shared period counter, 0..CYCLE-1
//   WR_EN     shadow write strobe
//   WR_ADDR   channel index for the write (out-of-range index is ignored)
//   WR_RISE   rise value to write
//   WR_FALL   fall value to write
//   COMMIT    one-cycle pulse arming a shadow-to-active transfer
//   OUT_EN    global output enable
//   PENDING   transfer armed but not yet applied
//   PWM_OUT   registered per-channel PWM outputs
// ---------------------------------------------------------------------------
module pwm_multi_generator #(
    parameter int WIDTH  = 13,
    parameter int CYCLE  = 4096,
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [WIDTH-1:0]  TIME_CNT,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [WIDTH-1:0]  WR_RISE,
    input  logic [WIDTH-1:0]  WR_FALL,
    input  logic              COMMIT,
    input  logic              OUT_EN,
    output logic              PENDING,
    output logic [NUM_CH-1:0] PWM_OUT
);

    localparam logic [WIDTH-1:0] LAST_TICK = WIDTH'(CYCLE - 1);

    logic [WIDTH-1:0]  shadow_rise_q [NUM_CH];
    logic [WIDTH-1:0]  shadow_rise_d [NUM_CH];
    logic [WIDTH-1:0]  shadow_fall_q [NUM_CH];
    logic [WIDTH-1:0]  shadow_fall_d [NUM_CH];
    logic [WIDTH-1:0]  active_rise_q [NUM_CH];
    logic [WIDTH-1:0]  active_rise_d [NUM_CH];
    logic [WIDTH-1:0]  active_fall_q [NUM_CH];
    logic [WIDTH-1:0]  active_fall_d [NUM_CH];
    logic              pending_q;
    logic              pending_d;
    logic [NUM_CH-1:0] pwm_q;
    logic [NUM_CH-1:0] pwm_d;

    logic              boundary;
    logic              transfer;

    // Window test. When fall < rise the high window wraps through t = 0.
    // rise == fall is an empty window, and rise = CYCLE / fall = 0 also
    // never matches because t never reaches CYCLE.
    function automatic logic pwm_on(input logic [WIDTH-1:0] r,
                                    input logic [WIDTH-1:0] f,
                                    input logic [WIDTH-1:0] t);
        logic on;
        if (r <= f) begin
            on = (t >= r) && (t < f);
        end else begin
            on = (t >= r) || (t < f);
        end
        return on;
    endfunction

    assign boundary = (TIME_CNT == LAST_TICK);
    assign transfer = boundary && pending_q;

    always_comb begin
        shadow_rise_d = shadow_rise_q;
        shadow_fall_d = shadow_fall_q;
        active_rise_d = active_rise_q;
        active_fall_d = active_fall_q;
        pending_d     = pending_q;
        pwm_d         = '0;

        // The transfer reads the shadow contents held before this edge, so a
        // write landing on the boundary cycle waits for the next commit.
        if (transfer) begin
            active_rise_d = shadow_rise_q;
            active_fall_d = shadow_fall_q;
        end

        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (WR_EN && (WR_ADDR == ADDR_W'(ch))) begin
                shadow_rise_d[ch] = WR_RISE;
                shadow_fall_d[ch] = WR_FALL;
            end
        end

        // A commit on the boundary cycle re-arms the following boundary even
        // though the current transfer consumes the previous arming.
        if (COMMIT) begin
            pending_d = 1'b1;
        end else if (transfer) begin
            pending_d = 1'b0;
        end

        // Outputs use the active values from before the edge; swapped values
        // first appear for t = 0 on the following edge.
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pwm_d[ch] = OUT_EN && pwm_on(active_rise_q[ch], active_fall_q[ch], TIME_CNT);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                shadow_rise_q[ch] <= '0;
                shadow_fall_q[ch] <= '0;
                active_rise_q[ch] <= '0;
                active_fall_q[ch] <= '0;
            end
            pending_q <= 1'b0;
            pwm_q     <= '0;
        end else begin
            shadow_rise_q <= shadow_rise_d;
            shadow_fall_q <= shadow_fall_d;
            active_rise_q <= active_rise_d;
            active_fall_q <= active_fall_d;
            pending_q     <= pending_d;
            pwm_q         <= pwm_d;
        end
    end

    assign PENDING = pending_q;
    assign PWM_OUT = pwm_q;

endmodule

// File: tb/tb_pwm_multi_generator.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_generator
//
// Drives the shared period counter and the write/commit port, keeps a
// behavioural model of shadow/active pairs and compares every output tick
// against it, plus per-period duty counts for the directed cases.
// ---------------------------------------------------------------------------
module tb_pwm_multi_generator;

    localparam int WIDTH  = 13;
    localparam int CYCLE  = 4096;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              rst_n;
    logic [WIDTH-1:0]  time_cnt;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_rise;
    logic [WIDTH-1:0]  wr_fall;
    logic              commit;
    logic              out_en;
    logic              pending;
    logic [NUM_CH-1:0] pwm_out;

    pwm_multi_generator #(
        .WIDTH  (WIDTH),
        .CYCLE  (CYCLE),
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .TIME_CNT (time_cnt),
        .WR_EN    (wr_en),
        .WR_ADDR  (wr_addr),
        .WR_RISE  (wr_rise),
        .WR_FALL  (wr_fall),
        .COMMIT   (commit),
        .OUT_EN   (out_en),
        .PENDING  (pending),
        .PWM_OUT  (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: plain integers per channel.
    int                m_sr [NUM_CH];
    int                m_sf [NUM_CH];
    int                m_ar [NUM_CH];
    int                m_af [NUM_CH];
    bit                m_pending;
    logic [NUM_CH-1:0] m_pwm;
    int                hi_cnt [NUM_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, obs, exp, time_cnt, $time);
        end
    endtask

    // High when t is inside [r, f), or outside [f, r) for a wrapped window.
    function automatic bit ref_on(input int r, input int f, input int t);
        if (r <= f) return (t >= r) && (t < f);
        return !((t >= f) && (t < r));
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_sr[ch] = 0; m_sf[ch] = 0; m_ar[ch] = 0; m_af[ch] = 0;
        end
        m_pending = 1'b0;
        m_pwm     = '0;
    endtask

    // Expected state after the coming clock edge, from the current inputs.
    task automatic model_step();
        bit last;
        if (!rst_n) begin
            model_reset();
        end else begin
            last = (int'(time_cnt) == CYCLE - 1);
            for (int ch = 0; ch < NUM_CH; ch++)
                m_pwm[ch] = out_en && ref_on(m_ar[ch], m_af[ch], int'(time_cnt));
            if (last && m_pending) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    m_ar[ch] = m_sr[ch];
                    m_af[ch] = m_sf[ch];
                end
            end
            if (wr_en && int'(wr_addr) < NUM_CH) begin
                m_sr[wr_addr] = int'(wr_rise);
                m_sf[wr_addr] = int'(wr_fall);
            end
            if (commit) m_pending = 1'b1;
            else if (last) m_pending = 1'b0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("pwm", 32'(pwm_out), 32'(m_pwm));
        chk("pending", 32'(pending), 32'(m_pending));
        for (int ch = 0; ch < NUM_CH; ch++) hi_cnt[ch] += int'(pwm_out[ch]);
        wr_en    = 1'b0;
        commit   = 1'b0;
        time_cnt = WIDTH'((int'(time_cnt) + 1) % CYCLE);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i <= CYCLE && int'(time_cnt) != target; i++) tick();
    endtask

    task automatic set_wr(input int ch, input int r, input int f);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(ch);
        wr_rise = WIDTH'(r);
        wr_fall = WIDTH'(f);
    endtask

    // One full period from t = 0; optionally write a channel at t = 10 and
    // commit at t = 11 so the new value is measured in the next period.
    task automatic measure_period(input bit do_wr, input bit do_commit,
                                  input int ch, input int r, input int f);
        run_to(0);
        for (int c = 0; c < NUM_CH; c++) hi_cnt[c] = 0;
        for (int i = 0; i < CYCLE; i++) begin
            if (do_wr && i == 10) set_wr(ch, r, f);
            if (do_commit && i == 11) commit = 1'b1;
            tick();
        end
    endtask

    function automatic int rand_val();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return CYCLE;
            default: return int'($urandom_range(0, CYCLE));
        endcase
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        time_cnt = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_rise  = '0;
        wr_fall  = '0;
        commit   = 1'b0;
        out_en   = 1'b0;
        model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) hi_cnt[ch] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_pwm", 32'(pwm_out), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        rst_n  = 1'b1;
        out_en = 1'b1;

        // No writes: a whole period of silence.
        measure_period(1'b0, 1'b0, 0, 0, 0);
        for (int ch = 0; ch < NUM_CH; ch++) chk("idle_duty", 32'(hi_cnt[ch]), 32'd0);

        // Load four channels, commit at t = 100.
        set_wr(0, 1024, 3072); tick();
        set_wr(1, 3072, 1024); tick();
        set_wr(2, 0, CYCLE);   tick();
        set_wr(3, 512, 1536);  tick();
        run_to(100);
        commit = 1'b1;
        tick();
        chk("commit_pending", 32'(pending), 32'd1);
        run_to(CYCLE - 1);
        chk("pending_hold", 32'(pending), 32'd1);
        tick();
        chk("pending_clear", 32'(pending), 32'd0);

        // ch2 edge cases, each measured one period after its commit.
        measure_period(1'b1, 1'b1, 2, 2048, 2048);
        chk("duty_ch0", 32'(hi_cnt[0]), 32'd2048);
        chk("duty_ch1", 32'(hi_cnt[1]), 32'd2048);
        chk("duty_ch2_full", 32'(hi_cnt[2]), 32'(CYCLE));
        chk("duty_ch3", 32'(hi_cnt[3]), 32'd1024);
        measure_period(1'b1, 1'b1, 2, CYCLE, 0);
        chk("duty_ch2_equal", 32'(hi_cnt[2]), 32'd0);
        measure_period(1'b1, 1'b1, 2, 2048, 0);
        chk("duty_ch2_rcycle", 32'(hi_cnt[2]), 32'd0);

        // ch3 shadow written without commit: old pair stays for two periods.
        measure_period(1'b1, 1'b0, 3, 0, 2048);
        chk("duty_ch2_wrap", 32'(hi_cnt[2]), 32'd2048);
        chk("ch3_held_1", 32'(hi_cnt[3]), 32'd1024);
        measure_period(1'b0, 1'b0, 0, 0, 0);
        chk("ch3_held_2", 32'(hi_cnt[3]), 32'd1024);

        // Commit early, then commit again on the boundary cycle itself.
        run_to(50);
        commit = 1'b1;
        tick();
        run_to(CYCLE - 1);
        commit = 1'b1;
        tick();
        chk("boundary_rearm", 32'(pending), 32'd1);

        // Mid-period shadow change on ch0 must not show before t = 0.
        measure_period(1'b1, 1'b0, 0, 100, 200);
        chk("ch3_transferred", 32'(hi_cnt[3]), 32'd2048);
        chk("ch0_unchanged", 32'(hi_cnt[0]), 32'd2048);

        // Output enable drop and restore.
        run_to(500);
        out_en = 1'b0;
        tick();
        chk("oe_off", 32'(pwm_out), 32'd0);
        run_to(600);
        out_en = 1'b1;
        tick();
        run_to(0);

        // Reset in mid-period while a commit is armed.
        set_wr(1, 777, 1777); tick();
        commit = 1'b1;
        tick();
        run_to(2000);
        chk("pre_reset_pending", 32'(pending), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", 32'(pwm_out), 32'd0);
        chk("async_rst_pending", 32'(pending), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        measure_period(1'b0, 1'b0, 0, 0, 0);
        for (int ch = 0; ch < NUM_CH; ch++) chk("post_reset_duty", 32'(hi_cnt[ch]), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3 * CYCLE; i++) begin
            if ($urandom_range(0, 63) == 0) set_wr(int'($urandom_range(0, NUM_CH - 1)), rand_val(), rand_val());
            if ($urandom_range(0, 511) == 0) commit = 1'b1;
            if ($urandom_range(0, 255) == 0) out_en = ~out_en;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_multi_generator.md
Name: pwm_multi_generator

Overview:
Multi-channel successor to the single-channel PWM generator.
- Drives NUM_CH PWM outputs from one shared TIME_CNT.
- Each channel has its own RISE/FALL pair, loaded through a write port into shadow registers.
- Shadow values become active only at a cycle boundary, so duty or phase changes never glitch mid-period.
- Sits between the modulation/duty-calc pipeline and the output drive stage.

Parameters:
WIDTH, 13, width of TIME_CNT and of RISE/FALL values (must hold 0..CYCLE inclusive)
CYCLE, 4096, PWM period in CLK ticks; TIME_CNT runs 0..CYCLE-1
NUM_CH, 4, number of independent PWM channels (1..256)
ADDR_W, 2, channel-address width, ceil(log2(NUM_CH)), minimum 1

Ports:
CLK  in  1  system clock (163.84 MHz domain)
RST_N  in  1  asynchronous active-low reset
TIME_CNT  in  WIDTH  shared period counter, 0..CYCLE-1
WR_EN  in  1  write strobe for shadow registers
WR_ADDR  in  ADDR_W  channel index for the write
WR_RISE  in  WIDTH  rise value to write
WR_FALL  in  WIDTH  fall value to write
COMMIT  in  1  one-cycle pulse; arms transfer of all shadows at the next boundary
OUT_EN  in  1  global output enable
PENDING  out  1  commit armed, not yet applied
PWM_OUT  out  NUM_CH  per-channel PWM outputs

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - all shadow and active RISE/FALL = 0;
  - PENDING = 0, PWM_OUT = 0.
- Write port:
  - WR_EN=1 loads shadow[WR_ADDR] <= {WR_RISE, WR_FALL} at the clock edge.
  - WR_ADDR >= NUM_CH: write ignored.
  - Writes never touch active registers directly.
- Boundary: the cycle with TIME_CNT == CYCLE-1.
  - If PENDING=1 at a boundary, every active[ch] <= shadow[ch] as held before that edge.
  - The first period using new values therefore starts at TIME_CNT=0.
- PENDING rules:
  - Set by COMMIT.
  - Cleared at a boundary edge where the transfer occurs.
  - COMMIT on the boundary cycle itself: transfer still happens if PENDING was already 1, and PENDING stays 1.
  - That COMMIT arms the following boundary.
  - A WR_EN on the boundary cycle lands in shadow only; it is not part of that transfer.
- Repeated COMMIT while PENDING=1 has no extra effect; later writes simply update the shadows.
- Output function per channel, with r=active RISE, f=active FALL, t=TIME_CNT:
  - r <= f: on = (r <= t) and (t < f)
  - f < r (wrap-around): on = (t >= r) or (t < f)
  - Unsigned compares at WIDTH bits; values up to CYCLE are legal.
  - r=f gives 0% duty.
  - r=0, f=CYCLE gives 100% duty.
  - r=CYCLE, f=0 gives 0% duty.
- Latency: PWM_OUT[ch] registered; the value after edge k reflects TIME_CNT and active values sampled at edge k (1-cycle latency).
  - Values swapped at the boundary edge drive the output computed for t=0, visible one edge later.
- OUT_EN=0: PWM_OUT <= 0 at the next edge; active/shadow state and PENDING unaffected.
- Reset mid-period: outputs drop to 0 immediately and pending updates are lost.
  - Output resumes at 0% duty until a new write plus COMMIT lands.
- TIME_CNT is assumed monotonic mod CYCLE; if the boundary is skipped, no transfer occurs until TIME_CNT == CYCLE-1 is seen.

Test Plan:
- Reset then OUT_EN=1, no writes -> all PWM_OUT = 0 for a full 4096-tick period; PENDING = 0.
- Write ch0 r=1024 f=3072, ch1 r=3072 f=1024, COMMIT at t=100 -> PENDING=1 until the edge after t=4095.
  - Next period, checked every tick against the formula with 1-cycle latency: ch0 high for t in [1024,3072); ch1 high for t>=3072 or t<1024.
- Edge cases on ch2 checked over a full period:
  - r=0 f=4096 -> high all period;
  - r=2048 f=2048 -> low;
  - r=4096 f=0 -> low;
  - r=2048 f=0 -> high t>=2048.
- Write ch3 r=0 f=2048 without COMMIT -> ch3 stays at its old values across two periods.
  - Then COMMIT on the t=4095 cycle with PENDING already 1 from an earlier COMMIT -> transfer happens and PENDING remains 1.
- Change shadows mid-period while active values are running -> no output change before t=0.
  - OUT_EN=0 at t=500 -> all outputs 0 from the next edge; re-enable restores the correct waveform on the next tick.
- Assert RST_N=0 at t=2000 while PENDING=1 -> PWM_OUT=0 immediately and PENDING=0.
  - After release, the previously written shadows are not applied.
